// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// A single full-adder cell is stepped over WIDTH operand bits, LSB first,
// one bit per clock, with a registered carry linking the bits. Operands
// arrive over a valid/ready handshake and the registered sum/carry-out
// leave over a second valid/ready handshake.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Full-adder sum bit.
    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    // Full-adder carry bit (majority of the three inputs).
    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (c & (a ^ b));
    endfunction

    state_t             state_r;
    state_t             state_next_s;

    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic               c_r;
    logic [WIDTH-1:0]   p_sh_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;

    logic               bit_sum_s;
    logic               carry_next_s;
    logic [WIDTH-1:0]   p_next_s;
    logic               last_bit_s;

    // Full-adder cell on the current LSBs plus the partial-sum shift value.
    // The concatenate-and-shift form also covers WIDTH=1 without a zero-width slice.
    always_comb begin
        bit_sum_s    = fa_sum(a_sh_r[0], b_sh_r[0], c_r);
        carry_next_s = fa_carry(a_sh_r[0], b_sh_r[0], c_r);
        p_next_s     = WIDTH'({bit_sum_s, p_sh_r} >> 1);
        last_bit_s   = (cnt_r == CNT_W'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: accept, run WIDTH bits, then wait for the consumer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_bit_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from state only, so no input reaches an output combinationally.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
            ST_RUN: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
            ST_DONE: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Datapath: load operands on accept, shift one bit per RUN cycle,
    // and capture the result only on the final RUN edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r <= {WIDTH{1'b0}};
            b_sh_r <= {WIDTH{1'b0}};
            c_r    <= 1'b0;
            p_sh_r <= {WIDTH{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            sum_r  <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh_r <= A;
                        b_sh_r <= B;
                        c_r    <= Cin;
                        cnt_r  <= {CNT_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    a_sh_r <= a_sh_r >> 1;
                    b_sh_r <= b_sh_r >> 1;
                    c_r    <= carry_next_s;
                    p_sh_r <= p_next_s;
                    cnt_r  <= cnt_r + CNT_W'(1);
                    if (last_bit_s) begin
                        sum_r  <= p_next_s;
                        cout_r <= carry_next_s;
                    end
                end
                ST_DONE: begin
                    sum_r  <= sum_r;
                    cout_r <= cout_r;
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign S    = sum_r;
    assign Cout = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases plus randomized
// adds on a WIDTH=8 instance, and a back-to-back case on a WIDTH=1 instance.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, Cin8, Cout8;
    logic [7:0] A8, B8, S8;

    logic       in_valid1, in_ready1, out_valid1, out_ready1, Cin1, Cout1;
    logic [0:0] A1, B1, S1;

    int tests_run    = 0;
    int tests_failed = 0;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .A(A8), .B(B8), .Cin(Cin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .S(S8), .Cout(Cout8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .A(A1), .B(B1), .Cin(Cin1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .S(S1), .Cout(Cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned addition, carry-out is bit 8.
    function automatic logic [8:0] ref_add8(input logic [7:0] a, input logic [7:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {8'd0, c};
    endfunction

    // Present operands, accept them, and wait for out_valid; checks latency and result.
    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic c, output logic [8:0] exp);
        int n;
        @(negedge clk);
        check_val("pre_in_ready", in_ready8, 1);
        A8 = a; B8 = b; Cin8 = c; in_valid8 = 1'b1; out_ready8 = 1'b0;
        @(negedge clk);
        in_valid8 = 1'b0;
        A8 = 8'($urandom); B8 = 8'($urandom); Cin8 = 1'($urandom);
        check_val("run_in_ready", in_ready8, 0);
        n = 0;
        while (!out_valid8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("latency", n, 8);
        exp = ref_add8(a, b, c);
        check_val("result", {Cout8, S8}, exp);
    endtask

    // Hold the result for some cycles, then complete the output handshake.
    task automatic release8(input logic [8:0] exp, input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("hold_valid", out_valid8, 1);
            check_val("hold_result", {Cout8, S8}, exp);
        end
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        check_val("post_hs_valid", out_valid8, 0);
        check_val("post_hs_ready", in_ready8, 1);
    endtask

    task automatic do_add8(input logic [7:0] a, input logic [7:0] b, input logic c, input int hold);
        logic [8:0] exp;
        launch8(a, b, c, exp);
        release8(exp, hold);
    endtask

    initial begin
        logic [8:0] exp;
        rst_n = 1'b1;
        in_valid8 = 1'b0; out_ready8 = 1'b0; A8 = 8'd0; B8 = 8'd0; Cin8 = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; A1 = 1'b0; B1 = 1'b0; Cin1 = 1'b0;

        // Asynchronous reset between edges
        #12;
        rst_n = 1'b0;
        #1;
        check_val("rst_in_ready", in_ready8, 1);
        check_val("rst_out_valid", out_valid8, 0);
        check_val("rst_S", S8, 8'h00);
        check_val("rst_Cout", Cout8, 0);
        check_val("rst1_in_ready", in_ready1, 1);
        check_val("rst1_out_valid", out_valid1, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic and carry-propagation adds
        do_add8(8'h00, 8'h00, 1'b1, 0);
        do_add8(8'h3C, 8'h42, 1'b0, 1);
        do_add8(8'hFF, 8'h01, 1'b0, 0);
        do_add8(8'hA5, 8'h5A, 1'b1, 2);

        // Backpressure: result held, operands 0x11 ignored
        launch8(8'h12, 8'h34, 1'b0, exp);
        for (int i = 0; i < 10; i++) begin
            in_valid8 = (i % 2 == 0);
            A8 = 8'h11; B8 = 8'h00; Cin8 = 1'b0;
            @(negedge clk);
            check_val("bp_out_valid", out_valid8, 1);
            check_val("bp_in_ready", in_ready8, 0);
            check_val("bp_result", {Cout8, S8}, exp);
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        check_val("bp_release_ready", in_ready8, 1);
        check_val("bp_release_valid", out_valid8, 0);
        @(negedge clk);
        check_val("bp_not_accepted", in_ready8, 1);
        check_val("bp_idle_valid", out_valid8, 0);

        // Reset in the middle of RUN
        @(negedge clk);
        A8 = 8'hFF; B8 = 8'hFF; Cin8 = 1'b1; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", out_valid8, 0);
        check_val("mid_rst_ready", in_ready8, 1);
        check_val("mid_rst_S", S8, 8'h00);
        check_val("mid_rst_Cout", Cout8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_val("aborted_no_result", out_valid8, 0);
        end
        do_add8(8'h01, 8'h01, 1'b0, 0);

        // Randomized adds with random consumer stalls
        for (int k = 0; k < 25; k++) begin
            do_add8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        // WIDTH=1: held in_valid through two back-to-back adds
        @(negedge clk);
        in_valid1 = 1'b1; out_ready1 = 1'b1;
        A1 = 1'b1; B1 = 1'b1; Cin1 = 1'b1;
        @(negedge clk);
        A1 = 1'b1; B1 = 1'b0; Cin1 = 1'b0;
        check_val("w1_run_ready", in_ready1, 0);
        check_val("w1_run_valid", out_valid1, 0);
        @(negedge clk);
        check_val("w1_a_valid", out_valid1, 1);
        check_val("w1_a_result", {Cout1, S1}, 2'b11);
        check_val("w1_a_ready", in_ready1, 0);
        @(negedge clk);
        check_val("w1_hs_valid", out_valid1, 0);
        check_val("w1_hs_ready", in_ready1, 1);
        @(negedge clk);
        check_val("w1_b_accept", in_ready1, 0);
        @(negedge clk);
        in_valid1 = 1'b0;
        check_val("w1_b_valid", out_valid1, 1);
        check_val("w1_b_result", {Cout1, S1}, 2'b01);
        @(negedge clk);
        out_ready1 = 1'b0;
        check_val("w1_end_valid", out_valid1, 0);
        check_val("w1_end_ready", in_ready1, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
